aes_enc_sched: RTL and testbench
================================

AES_ENC_SCHED -- requirements
Module: aes_enc_sched

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64: watchdog limit, in clk cycles, from core_start to core_done; used only when AES_SCHED_TIMEOUT_EN is defined.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req0_valid  input  1  requester 0 has an encryption job.
REQ-005 req0_ready  output  1  requester 0 job is accepted this cycle when req0_valid is also high.
REQ-006 req0_pt / req0_key  input  128 each  requester 0 plaintext and key.
REQ-007 req1_valid, req1_ready, req1_pt, req1_key: same as REQ-004..006, for requester 1.
REQ-008 core_start  output  1  single-cycle start pulse to the aes_encrypt_seq core.
REQ-009 core_pt / core_key  output  128 each  registered operands to the core; stable from core_start until core_done.
REQ-010 core_ct  input  128  core ciphertext; valid when core_done is high.
REQ-011 core_done  input  1  core completion flag.
REQ-012 rsp_valid  output  1  response available.
REQ-013 rsp_ready  input  1  consumer accepts the response.
REQ-014 rsp_id  output  1  requester index the response belongs to.
REQ-015 rsp_ct  output  128  ciphertext result.
REQ-016 rsp_err  output  1  job aborted by the watchdog; rsp_ct is all-zero when set.

Function
REQ-017 The FSM SHALL have four states: IDLE, START, BUSY, RESP.
REQ-018 IDLE: reqN_ready is high combinationally only for the arbitration winner; at most one ready is high per cycle.
REQ-019 Arbitration SHALL be round-robin:
- one valid requester: it wins;
- both valid: the requester not granted last wins.
REQ-020 On acceptance (valid&&ready), the block SHALL latch pt, key and id, and move IDLE->START.
REQ-021 START: core_start=1 for exactly one cycle, then START->BUSY.
REQ-022 BUSY: on core_done, the block SHALL capture core_ct into rsp_ct and move BUSY->RESP.
REQ-023 core_done outside BUSY SHALL be ignored.
REQ-024 RESP: rsp_valid is held high with rsp_id/rsp_ct stable until rsp_ready; on the handshake, RESP->IDLE and the round-robin pointer is updated to rsp_id.
REQ-025 No new request SHALL be accepted in START, BUSY or RESP; reqN_ready is 0 in those states.
REQ-026 Latency: acceptance at cycle T, core_start at T+1, rsp_valid at the cycle after core_done.
REQ-027 Back-to-back throughput: one job per (core latency + 3) cycles, with rsp_ready held high.
REQ-028 A requester dropping valid before ready SHALL forfeit the grant with no state change.

Reset
REQ-029 When rst is high, the block SHALL enter IDLE with:
- core_start=0, rsp_valid=0, rsp_id=0, rsp_err=0;
- rsp_ct, core_pt, core_key all-zero;
- round-robin pointer=1, so requester 0 wins the first tie.
REQ-030 rst in any state SHALL abort the job in flight; no response is produced for it.

Configuration
REQ-031 With AES_SCHED_TIMEOUT_EN defined, the block SHALL run a cycle counter in BUSY. If it reaches TIMEOUT_CYCLES without core_done, the FSM goes to RESP with rsp_err=1 and rsp_ct=0.
REQ-032 Without AES_SCHED_TIMEOUT_EN, there is no counter, rsp_err is tied 0, and BUSY waits indefinitely.

Structure
REQ-033 A shared package aes_pkg SHALL hold:
- the FSM state enum;
- AES_BLK_W=128;
- the requester count 2.
REQ-034 Round-robin grant logic SHALL be one sub-module, aes_rr_arb2.
REQ-035 The aes_encrypt_seq core SHALL be instantiated by the parent, not inside this block.

Verification (bench wires a real aes_encrypt_seq)
REQ-036 Single job: req0 with key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> rsp_id=0, rsp_ct=69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0.
REQ-037 Tie: both requesters valid with the same vector, starting from reset -> responses ordered id 0 then id 1; the second grant occurs in the cycle after the first rsp handshake.
REQ-038 Back-pressure: rsp_ready held low 10 cycles -> rsp_valid stays high with stable ct, and both reqN_ready stay 0 throughout.
REQ-039 Reset mid-BUSY: rst pulsed for 1 cycle -> no response; the next req1 job completes correctly with rsp_id=1.
REQ-040 With AES_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=8 and a stub core that never asserts done -> rsp_valid exactly 8 cycles after core_start, with rsp_err=1 and rsp_ct=0.
REQ-041 A spurious core_done injected in IDLE -> no rsp_valid.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared sizes and FSM state type for the AES encryption job scheduler.
package aes_pkg;
    localparam int AES_BLK_W = 128;
    localparam int AES_NREQ  = 2;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        RESP
    } sched_state_e;
endpackage

// File: rtl/aes_enc_sched_if.sv
// Request, core and response signals of the AES job scheduler.
// The scheduler uses the slave view; its environment uses the master view.
interface aes_enc_sched_if;
    import aes_pkg::*;

    logic                 req0_valid;
    logic                 req0_ready;
    logic [AES_BLK_W-1:0] req0_pt;
    logic [AES_BLK_W-1:0] req0_key;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [AES_BLK_W-1:0] req1_pt;
    logic [AES_BLK_W-1:0] req1_key;
    logic                 core_start;
    logic [AES_BLK_W-1:0] core_pt;
    logic [AES_BLK_W-1:0] core_key;
    logic [AES_BLK_W-1:0] core_ct;
    logic                 core_done;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [AES_BLK_W-1:0] rsp_ct;
    logic                 rsp_err;

    modport slave (
        input  req0_valid, req0_pt, req0_key,
        input  req1_valid, req1_pt, req1_key,
        input  core_ct, core_done, rsp_ready,
        output req0_ready, req1_ready,
        output core_start, core_pt, core_key,
        output rsp_valid, rsp_id, rsp_ct, rsp_err
    );

    modport master (
        output req0_valid, req0_pt, req0_key,
        output req1_valid, req1_pt, req1_key,
        output core_ct, core_done, rsp_ready,
        input  req0_ready, req1_ready,
        input  core_start, core_pt, core_key,
        input  rsp_valid, rsp_id, rsp_ct, rsp_err
    );
endinterface

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant: on a tie the requester not granted last wins.
module aes_rr_arb2 import aes_pkg::*; (
    input  logic                en_i,
    input  logic [AES_NREQ-1:0] valid_i,
    input  logic                last_i,
    output logic [AES_NREQ-1:0] gnt_o
);
    always_comb begin
        gnt_o = '0;
        if (en_i) begin
            if (&valid_i) begin
                gnt_o = last_i ? 2'b01 : 2'b10;
            end else begin
                gnt_o = valid_i;
            end
        end
    end
endmodule

// File: rtl/aes_enc_sched.sv
// Shares one external AES-128 core between two requesters, one job at a time.
// Optional BUSY watchdog enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_enc_sched import aes_pkg::*; #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic           clk,
    input  logic           rst,
    aes_enc_sched_if.slave bus
);
    sched_state_e         state_q, state_d;
    logic                 rr_q, rr_d;
    logic                 id_q, id_d;
    logic [AES_BLK_W-1:0] pt_q, pt_d;
    logic [AES_BLK_W-1:0] key_q, key_d;
    logic [AES_BLK_W-1:0] ct_q, ct_d;
    logic [AES_NREQ-1:0]  req_valid;
    logic [AES_NREQ-1:0]  gnt;
    logic                 tmo;

    assign req_valid = {bus.req1_valid, bus.req0_valid};

    aes_rr_arb2 u_arb (
        .en_i    (state_q == IDLE),
        .valid_i (req_valid),
        .last_i  (rr_q),
        .gnt_o   (gnt)
    );

`ifdef AES_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q holds cycles elapsed since core_start, so RESP lands TIMEOUT_CYCLES after it
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == START) begin
            cnt_d = CNT_W'(1);
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (bus.core_done) begin
                err_d = 1'b0;
            end else if (tmo) begin
                err_d = 1'b1;
            end
        end
    end

    assign tmo = (state_q == BUSY) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign tmo         = 1'b0;
    assign bus.rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        pt_d    = pt_q;
        key_d   = key_q;
        ct_d    = ct_q;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    id_d    = gnt[1];
                    pt_d    = gnt[1] ? bus.req1_pt  : bus.req0_pt;
                    key_d   = gnt[1] ? bus.req1_key : bus.req0_key;
                    state_d = START;
                end
            end
            START: state_d = BUSY;
            BUSY: begin
                if (bus.core_done) begin
                    ct_d    = bus.core_ct;
                    state_d = RESP;
                end else if (tmo) begin
                    ct_d    = '0;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rr_d    = id_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= 1'b1;
            id_q    <= 1'b0;
            pt_q    <= '0;
            key_q   <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            pt_q    <= pt_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.core_start = (state_q == START);
    assign bus.core_pt    = pt_q;
    assign bus.core_key   = key_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_ct     = ct_q;
endmodule

// File: tb/tb_aes_enc_sched.sv
// Bench for aes_enc_sched with a behavioural AES-128 core and a response scoreboard.
module tb_aes_enc_sched;
    import aes_pkg::*;

    localparam int LAT = 12;
    localparam int TMO = 8;
    localparam logic [AES_BLK_W-1:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [AES_BLK_W-1:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [AES_BLK_W-1:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [2047:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;

    typedef struct packed {
        logic                 id;
        logic [AES_BLK_W-1:0] ct;
        logic                 err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_enc_sched_if bus ();

    aes_enc_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0, start_cyc = 0, done_cyc = 0, hs_cyc = 0;
    int   n_rsp = 0;
    exp_t sb[$];
    logic tb_busy = 1'b0, prev_rv = 1'b0;
    logic last_id = 1'b0;
    logic [1:0] id_hist = 2'b00;
    logic gap_en = 1'b0, gap_id = 1'b0;
    logic skip_stab = 1'b0, core_dead = 1'b0;
    logic [AES_BLK_W-1:0] exp_ct0, exp_ct1;

    // behavioural core
    logic                 mdl_busy = 1'b0, mdl_done = 1'b0;
    int                   mdl_cnt = 0;
    logic [AES_BLK_W-1:0] mdl_pt = '0, mdl_key = '0, mdl_ct = '0;
    logic                 spur_done = 1'b0;
    logic [AES_BLK_W-1:0] spur_ct = '0;

    assign bus.core_done = mdl_done | spur_done;
    assign bus.core_ct   = spur_done ? spur_ct : mdl_ct;

    task automatic check(input string tag, input logic [AES_BLK_W-1:0] got,
                         input logic [AES_BLK_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sb_byte(input logic [7:0] x);
        logic [2047:0] t;
        t = SBOX;
        return t[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [AES_BLK_W-1:0] aes_enc(input logic [AES_BLK_W-1:0] pt,
                                                      input logic [AES_BLK_W-1:0] key);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [31:0] tmp;
        logic [7:0]  rc, a0, a1, a2, a3;
        logic [AES_BLK_W-1:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i - 1];
            if (i % 4 == 0) begin
                tmp = {sb_byte(tmp[23:16]), sb_byte(tmp[15:8]), sb_byte(tmp[7:0]),
                       sb_byte(tmp[31:24])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i - 4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8 * i -: 8] ^ key[127 - 8 * i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb_byte(s[i]);
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4 * c] = t[row + 4 * ((c + row) % 4)];
            if (r != 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
                    s[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4 * r + i / 4][31 - 8 * (i % 4) -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = s[i];
        return o;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // core model is not tied to rst, so an aborted job still raises done later
    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (bus.core_start && !core_dead) begin
            mdl_pt   <= bus.core_pt;
            mdl_key  <= bus.core_key;
            mdl_cnt  <= LAT;
            mdl_busy <= 1'b1;
        end else if (mdl_busy) begin
            if (mdl_cnt == 1) begin
                mdl_done <= 1'b1;
                mdl_ct   <= aes_enc(mdl_pt, mdl_key);
                mdl_busy <= 1'b0;
            end else begin
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            sb.delete();
            tb_busy = 1'b0;
            prev_rv = 1'b0;
        end else begin
            check("ready_excl", 128'(bus.req0_ready & bus.req1_ready), 128'(0));
            check("ready_busy", 128'((bus.req0_ready | bus.req1_ready) & tb_busy), 128'(0));
            if (bus.core_start) begin
                check("start_lat", 128'(cyc), 128'(acc_cyc + 1));
                start_cyc = cyc;
            end
            if (bus.core_done) begin
                done_cyc = cyc;
                if (mdl_done && !skip_stab) begin
                    check("core_pt_hold", bus.core_pt, mdl_pt);
                    check("core_key_hold", bus.core_key, mdl_key);
                end
            end
            if (bus.rsp_valid && !prev_rv) begin
                if (core_dead) check("tmo_lat", 128'(cyc), 128'(start_cyc + TMO));
                else           check("rsp_lat", 128'(cyc), 128'(done_cyc + 1));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 128'(1), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("rsp_id", 128'(bus.rsp_id), 128'(e.id));
                    check("rsp_ct", bus.rsp_ct, e.ct);
                    check("rsp_err", 128'(bus.rsp_err), 128'(e.err));
                end
                last_id = bus.rsp_id;
                id_hist = {id_hist[0], bus.rsp_id};
                hs_cyc  = cyc;
                tb_busy = 1'b0;
                n_rsp++;
            end
            if (bus.req0_valid && bus.req0_ready) begin
                sb.push_back('{id: 1'b0, ct: core_dead ? '0 : exp_ct0, err: core_dead});
                if (gap_en && !gap_id) check("regrant_gap", 128'(cyc), 128'(hs_cyc + 1));
                acc_cyc = cyc;
                tb_busy = 1'b1;
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sb.push_back('{id: 1'b1, ct: core_dead ? '0 : exp_ct1, err: core_dead});
                if (gap_en && gap_id) check("regrant_gap", 128'(cyc), 128'(hs_cyc + 1));
                acc_cyc = cyc;
                tb_busy = 1'b1;
            end
            prev_rv = bus.rsp_valid;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [AES_BLK_W-1:0] pt,
                           input logic [AES_BLK_W-1:0] key, input logic [AES_BLK_W-1:0] ct);
        if (r == 0) begin
            bus.req0_pt = pt; bus.req0_key = key; exp_ct0 = ct; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_pt = pt; bus.req1_key = key; exp_ct1 = ct; bus.req1_valid = 1'b1;
        end
    endtask

    task automatic wait_accept(input int r);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin
            @(negedge clk);
            got = (r == 0) ? (bus.req0_valid && bus.req0_ready)
                           : (bus.req1_valid && bus.req1_ready);
        end
        if (!got) check("accept_wait", 128'(0), 128'(1));
        @(posedge clk); #1;
        if (r == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 200 && n_rsp < target; k++) @(posedge clk);
        if (n_rsp < target) check("rsp_wait", 128'(n_rsp), 128'(target));
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [AES_BLK_W-1:0] p, k, ct_cap;
        logic id_cap;
        int   n0;
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_pt = '0; bus.req0_key = '0;
        bus.req1_valid = 1'b0; bus.req1_pt = '0; bus.req1_key = '0;
        bus.rsp_ready = 1'b0;
        exp_ct0 = '0; exp_ct1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_core_start", 128'(bus.core_start), 128'(0));
        check("rst_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("rst_rsp_id", 128'(bus.rsp_id), 128'(0));
        check("rst_rsp_err", 128'(bus.rsp_err), 128'(0));
        check("rst_rsp_ct", bus.rsp_ct, '0);
        check("rst_core_pt", bus.core_pt, '0);
        check("rst_core_key", bus.core_key, '0);
        @(posedge clk); #1 rst = 1'b0;

        // stray core_done while idle
        spur_ct = {$urandom, $urandom, $urandom, $urandom};
        spur_done = 1'b1;
        @(posedge clk); #1 spur_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("spur_rsp_valid", 128'(bus.rsp_valid), 128'(0));
        end
        check("spur_core_start", 128'(bus.core_start), 128'(0));

        // single known-answer job
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        n0 = n_rsp;
        set_req(0, PT_A, KEY_A, CT_A);
        wait_accept(0);
        wait_rsp(n0 + 1);

        // tie straight out of reset: requester 0 first, requester 1 right after handshake
        do_reset();
        n0 = n_rsp;
        set_req(0, PT_A, KEY_A, CT_A);
        set_req(1, PT_A, KEY_A, CT_A);
        gap_en = 1'b1; gap_id = 1'b1;
        wait_accept(0);
        wait_accept(1);
        gap_en = 1'b0;
        wait_rsp(n0 + 2);
        check("tie_order_rst", 128'(id_hist), 128'(2'b01));

        // requester 0 served last, so a tie now goes to requester 1
        n0 = n_rsp;
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        set_req(0, p, k, aes_enc(p, k));
        wait_accept(0);
        wait_rsp(n0 + 1);
        set_req(0, k, p, aes_enc(k, p));
        set_req(1, p, ~k, aes_enc(p, ~k));
        gap_en = 1'b1; gap_id = 1'b0;
        wait_accept(1);
        wait_accept(0);
        gap_en = 1'b0;
        wait_rsp(n0 + 3);
        check("tie_order_rr", 128'(id_hist), 128'(2'b10));

        // back-pressure with a competing request held pending
        bus.rsp_ready = 1'b0;
        n0 = n_rsp;
        p = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        set_req(0, p, k, aes_enc(p, k));
        wait_accept(0);
        for (int i = 0; i < 60 && !bus.rsp_valid; i++) @(negedge clk);
        check("bp_rsp_seen", 128'(bus.rsp_valid), 128'(1));
        set_req(1, k, p, aes_enc(k, p));
        ct_cap = bus.rsp_ct;
        id_cap = bus.rsp_id;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_valid", 128'(bus.rsp_valid), 128'(1));
            check("bp_ct", bus.rsp_ct, ct_cap);
            check("bp_id", 128'(bus.rsp_id), 128'(id_cap));
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        wait_accept(1);
        wait_rsp(n0 + 2);

        // reset pulse while the core is busy drops that job
        p = {$urandom, $urandom, $urandom, $urandom};
        set_req(0, p, KEY_A, aes_enc(p, KEY_A));
        wait_accept(0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        skip_stab = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n0 = n_rsp;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("rst_abort_no_rsp", 128'(bus.rsp_valid), 128'(0));
        end
        check("rst_abort_count", 128'(n_rsp), 128'(n0));
        skip_stab = 1'b0;
        @(posedge clk); #1;
        set_req(1, PT_A, KEY_A, CT_A);
        wait_accept(1);
        wait_rsp(n0 + 1);
        check("rst_next_id", 128'(last_id), 128'(1));

`ifdef AES_SCHED_TIMEOUT_EN
        // core never answers: watchdog reports an error response
        core_dead = 1'b1;
        n0 = n_rsp;
        set_req(0, PT_A, KEY_A, CT_A);
        wait_accept(0);
        wait_rsp(n0 + 1);
        core_dead = 1'b0;
        check("tmo_last_id", 128'(last_id), 128'(0));
`endif

        repeat (3) @(posedge clk);
        check("sb_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
